demux_scheduler: RTL and testbench
==================================

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter: BURST, default 4, bits delivered per channel grant; legal range 1..16.
REQ-002 Port: clk  in  1  single clock; all logic rising-edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Port: en_mask  in  8  per-channel enable; bit i = channel i may be granted.
REQ-005 Port: in_valid  in  1  upstream data bit valid.
REQ-006 Port: in_data  in  1  upstream serial data bit.
REQ-007 Port: in_ready  out  1  scheduler accepts in_data this cycle.
REQ-008 Port: sel  out  3  channel select to the 1-to-8 demux; sel[2] drives s0 (MSB), sel[0] drives s2 (LSB).
REQ-009 Port: dmx_out  out  1  registered data bit driven into the demux data input.
REQ-010 Port: ch_active  out  8  one-hot of granted channel, 0 when none is granted.
REQ-011 Port: burst_done  out  1  one-cycle pulse when a channel completes BURST beats.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, XFER, DRAIN.
REQ-013 IDLE: in_ready=0; when en_mask!=0, pick the first set bit at or above ptr (wrapping 7->0), register sel/cur, go SETUP; when en_mask==0, stay IDLE.
REQ-014 SETUP: exactly one cycle; sel stable; in_ready=0; dmx_out=0; go XFER.
REQ-015 XFER: in_ready = en_mask[cur]; accept = in_valid && in_ready.
REQ-016 On accept, dmx_out SHALL equal in_data in the following cycle (latency 1); with no accept, dmx_out=0 in the following cycle.
REQ-017 beat_cnt increments per accept; the accept with beat_cnt==BURST-1 SHALL assert burst_done that same cycle and go DRAIN.
REQ-018 en_mask[cur] low in XFER: in_ready low the same cycle, go DRAIN, no burst_done (abort).
REQ-019 DRAIN: one cycle; in_ready=0; sel held; presents the last accepted bit; ptr <= cur+1 mod 8; beat_cnt <= 0; go IDLE.
REQ-020 sel SHALL change only on the IDLE->SETUP edge; stable throughout SETUP, XFER, DRAIN.
REQ-021 ch_active = one-hot(cur) in SETUP/XFER/DRAIN, 0 in IDLE.
REQ-022 en_mask changes for channels other than cur SHALL take effect only at the next IDLE arbitration.
REQ-023 in_valid without in_ready SHALL be ignored; no data buffering inside the block.

Reset
REQ-024 While rst_n=0 at a clock edge: state=IDLE, ptr=0, cur=0, beat_cnt=0, sel=0, dmx_out=0, ch_active=0, burst_done=0, in_ready=0.
REQ-025 Reset mid-burst SHALL discard the burst without a burst_done pulse; first grant after release is the lowest enabled channel.

Structure
REQ-026 Shared package demux_sched_pkg SHALL hold NCH=8, SEL_W=3, the FSM state enum, and the beat-counter width (4).
REQ-027 Sub-module rr_pick (combinational: mask, start pointer -> index, found flag) SHALL implement the rotating priority search.
REQ-028 Implementation target: single clocked process plus combinational next-state/output logic, about 150-250 lines.

Verification
REQ-029 rst_n=0 for 2 cycles with en_mask=8'hFF, in_valid=1 -> all outputs 0; SETUP (sel=0) one cycle after release, in_ready=1 the cycle after.
REQ-030 BURST=4, en_mask=8'hFF, in_valid=1, in_data=1,0,1,1 repeated -> sel 0,1,...,7,0; 4 accepts per channel; one burst_done per channel; dmx_out = in_data delayed 1 cycle; 7-cycle grant period (SETUP+4 XFER+DRAIN+IDLE).
REQ-031 en_mask=8'b1000_0100 -> sel alternates 2,7,2,7; ch_active alternates 8'h04/8'h80.
REQ-032 Channel 3 granted, en_mask[3] cleared after 2 accepts -> in_ready=0 same cycle, no burst_done, DRAIN, next grant channel 4 if enabled.
REQ-033 in_valid asserted every other cycle, BURST=4 -> XFER lasts 8 cycles; dmx_out=0 in cycles after non-accept.
REQ-034 rst_n low during beat 2 on channel 5 -> next cycle all outputs 0, no burst_done; after release, grant goes to channel 0.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared constants and FSM state type for the serial demux scheduler.
package demux_sched_pkg;

   localparam int unsigned NCH   = 8;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/demux_scheduler_rr_pick.sv
// Rotating-priority search: first set mask bit at or above start_i, wrapping to 0.
module rr_pick
   import demux_sched_pkg::*;
(
   input  logic [NCH-1:0]   mask_i,
   input  logic [SEL_W-1:0] start_i,
   output logic [SEL_W-1:0] idx_o,
   output logic             found_o
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      cand    = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         cand = start_i + SEL_W'(i);
         if (!found_o && mask_i[cand]) begin
            idx_o   = cand;
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_scheduler.sv
// Grants the serial input stream to one of 8 demux channels, BURST bits per grant,
// round-robin over the enabled channels.
module demux_scheduler
   import demux_sched_pkg::*;
#(
   parameter int unsigned BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   en_mask,
   input  logic             in_valid,
   input  logic             in_data,
   output logic             in_ready,
   output logic [SEL_W-1:0] sel,
   output logic             dmx_out,
   output logic [NCH-1:0]   ch_active,
   output logic             burst_done
);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic             dmx_q, dmx_d;
   logic [NCH-1:0]   act_q, act_d;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_found;
   logic             accept;

   rr_pick u_pick (
      .mask_i  (en_mask),
      .start_i (ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   // Next-state and combinational handshake outputs
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cur_d      = cur_q;
      beat_d     = beat_q;
      act_d      = act_q;
      dmx_d      = 1'b0;
      in_ready   = 1'b0;
      burst_done = 1'b0;
      accept     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               cur_d   = pick_idx;
               act_d   = NCH'(1) << pick_idx;
               state_d = SETUP;
            end
         end
         SETUP: state_d = XFER;
         XFER: begin
            in_ready = en_mask[cur_q];
            accept   = in_valid && in_ready;
            // A channel disabled mid-burst aborts without a completion pulse
            if (!en_mask[cur_q]) begin
               state_d = DRAIN;
            end else if (accept) begin
               dmx_d  = in_data;
               beat_d = beat_q + 1'b1;
               if (beat_q == CNT_W'(BURST - 1)) begin
                  burst_done = 1'b1;
                  state_d    = DRAIN;
               end
            end
         end
         DRAIN: begin
            ptr_d   = cur_q + 1'b1;
            beat_d  = '0;
            act_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cur_q   <= '0;
         beat_q  <= '0;
         dmx_q   <= 1'b0;
         act_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cur_q   <= cur_d;
         beat_q  <= beat_d;
         dmx_q   <= dmx_d;
         act_q   <= act_d;
      end
   end

   assign sel       = cur_q;
   assign dmx_out   = dmx_q;
   assign ch_active = act_q;

endmodule

// File: tb/tb_demux_scheduler.sv
// Scoreboard bench: stimulus queues expected grants, a negedge monitor checks them.
module tb_demux_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] en_mask;
   logic       in_valid;
   logic       in_data;
   logic       in_ready;
   logic [2:0] sel;
   logic       dmx_out;
   logic [7:0] ch_active;
   logic       burst_done;

   demux_scheduler #(.BURST(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_mask    (en_mask),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .sel        (sel),
      .dmx_out    (dmx_out),
      .ch_active  (ch_active),
      .burst_done (burst_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;     // expected channel
      int beats;  // expected accepts during the grant
      int done;   // expected burst_done pulses
      int len;    // expected active cycles, 0 = unchecked
      int gap;    // expected idle cycles before grant, -1 = unchecked
   } rec_t;

   rec_t        sb_q[$];
   rec_t        cur_rec;
   int          n_checks = 0;
   int          n_pass   = 0;
   int unsigned cyc      = 0;
   logic [3:0]  pat      = 4'b1011;
   bit          toggle_valid = 1'b0;
   bit          started  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push(input int ch, input int beats, input int done, input int len, input int gap);
      rec_t r;
      r.ch = ch; r.beats = beats; r.done = done; r.len = len; r.gap = gap;
      sb_q.push_back(r);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      cyc++;
      in_data = pat[2'(3 - (cyc % 4))];
      if (toggle_valid) in_valid = ~in_valid;
   endtask

   task automatic wait_grant(input logic [7:0] oh, input bit need_ready);
      int n = 0;
      while (!(ch_active == oh && (!need_ready || in_ready)) && n < 100) begin
         step();
         n++;
      end
      chk("wait_grant_timeout", 32'(n < 100), 1);
   endtask

   // Let queued grants finish, then close en_mask while IDLE still arbitrates
   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || ch_active != 8'h00) && n < 400) begin
         step();
         n++;
      end
      en_mask = 8'h00;
      chk("drain_timeout", 32'(n < 400), 1);
      repeat (3) step();
   endtask

   // Monitor
   logic       acc;
   logic       prev_acc = 1'b0;
   logic       prev_bit = 1'b0;
   logic [7:0] prev_act = 8'h00;
   bit         in_grant = 1'b0;
   int         nacc, ndone, len_cnt, idle_cnt;

   always @(negedge clk) begin
      if (started) begin
         chk("dmx_out_latency", 32'(dmx_out), prev_acc ? 32'(prev_bit) : 32'd0);
         acc = rst_n && in_valid && in_ready;
         if (ch_active != 8'h00) begin
            if (prev_act == 8'h00) begin
               chk("grant_expected", 32'(sb_q.size() != 0), 1);
               if (sb_q.size() != 0) begin
                  cur_rec = sb_q.pop_front();
                  chk("grant_sel", 32'(sel), cur_rec.ch);
                  chk("setup_ready", 32'(in_ready), 0);
                  if (cur_rec.gap >= 0) chk("grant_gap", idle_cnt, cur_rec.gap);
                  in_grant = 1'b1;
                  nacc = 0; ndone = 0; len_cnt = 0;
               end
               idle_cnt = 0;
            end
            if (in_grant) begin
               len_cnt++;
               chk("sel_stable", 32'(sel), cur_rec.ch);
               chk("ch_active_onehot", 32'(ch_active), 32'(8'h01 << cur_rec.ch));
               if (acc) nacc++;
               if (burst_done) begin
                  ndone++;
                  chk("done_on_accept", 32'(acc), 1);
               end
            end
         end else begin
            chk("idle_ready_done", {30'd0, in_ready, burst_done}, 0);
            idle_cnt++;
            if (prev_act != 8'h00 && in_grant) begin
               chk("grant_beats", nacc, cur_rec.beats);
               chk("grant_done", ndone, cur_rec.done);
               if (cur_rec.len > 0) chk("grant_len", len_cnt, cur_rec.len);
               in_grant = 1'b0;
            end
         end
         prev_acc = acc;
         prev_bit = in_data;
         prev_act = ch_active;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      en_mask  = 8'hFF;
      in_valid = 1'b1;
      in_data  = 1'b1;

      // Reset with everything requesting
      step();
      started = 1'b1;
      chk("rst_outputs", {in_ready, sel, dmx_out, ch_active, burst_done}, 0);
      step();
      chk("rst_outputs_2", {in_ready, sel, dmx_out, ch_active, burst_done}, 0);

      // Full round robin over all channels, back to channel 0
      push(0, 4, 1, 6, -1);
      for (int c = 1; c < 8; c++) push(c, 4, 1, 6, 1);
      push(0, 4, 1, 6, 1);
      rst_n = 1'b1;
      step();
      chk("first_setup_sel", 32'(sel), 0);
      chk("first_setup_act", 32'(ch_active), 32'h01);
      chk("first_setup_ready", 32'(in_ready), 0);
      step();
      chk("first_xfer_ready", 32'(in_ready), 1);
      drain();

      // Two sparse channels alternate
      push(2, 4, 1, 6, -1);
      push(7, 4, 1, 6, 1);
      push(2, 4, 1, 6, 1);
      push(7, 4, 1, 6, 1);
      en_mask = 8'b1000_0100;
      drain();

      // Abort channel 3 after two accepts, channel 4 follows
      push(3, 2, 0, 5, -1);
      push(4, 4, 1, 6, 1);
      en_mask = 8'h18;
      wait_grant(8'h08, 1'b1);
      step();
      step();
      en_mask = 8'h10;
      #1;
      chk("abort_ready_low", 32'(in_ready), 0);
      chk("abort_no_done", 32'(burst_done), 0);
      drain();

      // Half-rate valid stretches XFER to 8 cycles
      push(0, 4, 1, 10, -1);
      en_mask = 8'h01;
      wait_grant(8'h01, 1'b0);
      in_valid = 1'b1;
      toggle_valid = 1'b1;
      drain();
      toggle_valid = 1'b0;
      in_valid = 1'b1;

      // Reset during beat 2 on channel 5; restart at channel 0
      push(5, 1, 0, 3, -1);
      en_mask = 8'h20;
      wait_grant(8'h20, 1'b1);
      step();
      rst_n   = 1'b0;
      en_mask = 8'hFF;
      #1;
      chk("pre_rst_no_done", 32'(burst_done), 0);
      step();
      chk("midburst_rst_outputs", {in_ready, sel, dmx_out, ch_active, burst_done}, 0);
      push(0, 4, 1, 6, -1);
      rst_n = 1'b1;
      step();
      chk("post_rst_sel", 32'(sel), 0);
      drain();

      chk("scoreboard_empty", 32'(sb_q.size()), 0);
      chk("no_open_grant", 32'(in_grant), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
